// File: rtl/semaphore_bank_pkg.sv
// Shared opcodes and width helpers for the semaphore bank and its arbiter.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package semaphore_bank_pkg;

    // Per-core opcode encoding
    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_ACQUIRE = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;
    localparam logic [1:0] OP_WRITE   = 2'b11;

    // Width of an owner / core index; never below 1 so vectors stay legal
    function automatic int owner_w(input int cores);
        return (cores > 1) ? $clog2(cores) : 1;
    endfunction

    // Width of a semaphore entry index; never below 1 so vectors stay legal
    function automatic int index_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant and binary index for the first requester at or after the pointer.
// Latency: combinational grant; the pointer moves past the winner at the clock edge of a grant.
// Backpressure: none; requesters simply stay unserved until their turn comes round.
module rr_arbiter
    import semaphore_bank_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_i,
    output logic [N-1:0]          gnt_o,
    output logic [owner_w(N)-1:0] gnt_idx_o,
    output logic                  gnt_vld_o
);

    localparam int IW = owner_w(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Search from ptr_q upward with wrap; the first requesting slot wins and the pointer moves just past it
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        ptr_d     = ptr_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!gnt_vld_o && req_i[j] && (((int'(ptr_q) + i) % N) == j)) begin
                    gnt_vld_o = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IW'(j);
                    ptr_d     = IW'((j + 1) % N);
                end
            end
        end
    end

    // Pointer register; reset to 0 so core 0 has first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/semaphore_bank.sv
// Hardware semaphore bank: lock/owner/data entries shared by several cores, one arbitrated op per cycle.
// Latency: op executes at the grant edge; Ack/Status/Data registered and valid the following cycle.
// Backpressure: a core holds its request until Ack; it is not eligible again in its own Ack cycle.
module semaphore_bank
    import semaphore_bank_pkg::*;
#(
    parameter int NumberOfSemaphores = 4,
    parameter int NumberOfCores      = 2,
    parameter int DataWidth          = 4,
    parameter int AddrWidth          = 8    // up to 32 bits; must index every entry
) (
    input  logic                                             SEMAPHOREBANK_Clk,
    input  logic                                             SEMAPHOREBANK_Reset_n,
    input  logic [NumberOfCores-1:0]                         SEMAPHOREBANK_Req_fromCPU,
    input  logic [2*NumberOfCores-1:0]                       SEMAPHOREBANK_Op_fromCPU,
    input  logic [AddrWidth*NumberOfCores-1:0]               SEMAPHOREBANK_Addr_fromCPU,
    input  logic [DataWidth*NumberOfCores-1:0]               SEMAPHOREBANK_Data_fromCPU,
    input  logic [NumberOfCores-1:0]                         SEMAPHOREBANK_CoreReset_fromCPU,
    output logic [NumberOfCores-1:0]                         SEMAPHOREBANK_Ack_toCPU,
    output logic [NumberOfCores-1:0]                         SEMAPHOREBANK_Status_toCPU,
    output logic [DataWidth*NumberOfCores-1:0]               SEMAPHOREBANK_Data_toCPU,
    output logic [NumberOfSemaphores-1:0]                    SEMAPHOREBANK_Locked,
    output logic [owner_w(NumberOfCores)*NumberOfSemaphores-1:0] SEMAPHOREBANK_Owner
);

    localparam int C  = NumberOfCores;
    localparam int S  = NumberOfSemaphores;
    localparam int DW = DataWidth;
    localparam int AW = AddrWidth;
    localparam int OW = owner_w(NumberOfCores);

    // Entry state
    logic [S-1:0]               locked_q, locked_d;
    logic [S-1:0][OW-1:0]       owner_q,  owner_d;
    logic [S-1:0][DW-1:0]       data_q,   data_d;

    // Response registers
    logic [C-1:0]               ack_q,    ack_d;
    logic [C-1:0]               status_q, status_d;
    logic [C-1:0][DW-1:0]       rdata_q,  rdata_d;

    // Arbitration
    logic [C-1:0]               eligible;
    logic [C-1:0]               gnt;
    logic [OW-1:0]              gnt_idx;
    logic                       gnt_vld;

    // Granted request, decoded
    logic [1:0]                 sel_op;
    logic [AW-1:0]              sel_addr;
    logic [DW-1:0]              sel_wdata;
    logic                       addr_ok;
    logic [S-1:0]               hit;
    logic                       cur_locked;
    logic [OW-1:0]              cur_owner;
    logic [DW-1:0]              cur_data;
    logic                       owned;
    logic                       op_ok;
    logic                       do_lock;
    logic                       do_unlock;
    logic                       do_write;

    // A core whose Ack is showing this cycle has just been served and sits out one arbitration round
    assign eligible = SEMAPHOREBANK_Req_fromCPU & ~ack_q;

    rr_arbiter #(
        .N (C)
    ) u_arb (
        .clk       (SEMAPHOREBANK_Clk),
        .rst_n     (SEMAPHOREBANK_Reset_n),
        .req_i     (eligible),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Pull the winning core's opcode, address and write data out of the flat input buses
    always_comb begin
        sel_op    = OP_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < C; k++) begin
            if (gnt[k]) begin
                sel_op    = SEMAPHOREBANK_Op_fromCPU[2*k +: 2];
                sel_addr  = SEMAPHOREBANK_Addr_fromCPU[AW*k +: AW];
                sel_wdata = SEMAPHOREBANK_Data_fromCPU[DW*k +: DW];
            end
        end
    end

    // Out-of-range addresses match no entry, so they read back zero and change nothing
    assign addr_ok = gnt_vld && (32'(sel_addr) < 32'(S));

    // Look up the addressed entry's state as it was before this edge
    always_comb begin
        hit        = '0;
        cur_locked = 1'b0;
        cur_owner  = '0;
        cur_data   = '0;
        for (int e = 0; e < S; e++) begin
            if (addr_ok && (32'(sel_addr) == 32'(e))) begin
                hit[e]     = 1'b1;
                cur_locked = locked_q[e];
                cur_owner  = owner_q[e];
                cur_data   = data_q[e];
            end
        end
    end

    assign owned = cur_locked && (cur_owner == gnt_idx);

    // Decide the op's outcome and which state updates it requests
    always_comb begin
        op_ok     = 1'b0;
        do_lock   = 1'b0;
        do_unlock = 1'b0;
        do_write  = 1'b0;
        if (addr_ok) begin
            case (sel_op)
                OP_READ: begin
                    op_ok = owned;
                end
                OP_ACQUIRE: begin
                    op_ok   = !cur_locked || owned;
                    do_lock = !cur_locked;
                end
                OP_RELEASE: begin
                    op_ok     = owned;
                    do_unlock = owned;
                end
                default: begin
                    op_ok    = owned;
                    do_write = owned;
                end
            endcase
        end
    end

    // Entry next state: apply the granted op, then let forced release win on entries of a resetting core.
    // Forced release looks at pre-edge ownership, so an entry acquired in the same cycle is kept.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        data_d   = data_q;
        for (int e = 0; e < S; e++) begin
            if (hit[e]) begin
                if (do_lock) begin
                    locked_d[e] = 1'b1;
                    owner_d[e]  = gnt_idx;
                end
                if (do_unlock) begin
                    locked_d[e] = 1'b0;
                    owner_d[e]  = '0;
                end
                if (do_write) begin
                    data_d[e] = sel_wdata;
                end
            end
            for (int k = 0; k < C; k++) begin
                if (SEMAPHOREBANK_CoreReset_fromCPU[k] && locked_q[e] && (owner_q[e] == OW'(k))) begin
                    locked_d[e] = 1'b0;
                    owner_d[e]  = '0;
                end
            end
        end
    end

    // Response for the granted core only; every other core sees zeros
    always_comb begin
        ack_d    = '0;
        status_d = '0;
        rdata_d  = '0;
        for (int k = 0; k < C; k++) begin
            if (gnt[k]) begin
                ack_d[k]    = 1'b1;
                status_d[k] = op_ok;
                rdata_d[k]  = cur_data;
            end
        end
    end

    // Entry and response registers; reset drops any in-flight response
    always_ff @(posedge SEMAPHOREBANK_Clk or negedge SEMAPHOREBANK_Reset_n) begin
        if (!SEMAPHOREBANK_Reset_n) begin
            locked_q <= '0;
            owner_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            status_q <= '0;
            rdata_q  <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign SEMAPHOREBANK_Ack_toCPU    = ack_q;
    assign SEMAPHOREBANK_Status_toCPU = status_q;
    assign SEMAPHOREBANK_Data_toCPU   = rdata_q;
    assign SEMAPHOREBANK_Locked       = locked_q;
    assign SEMAPHOREBANK_Owner        = owner_q;

endmodule

// File: tb/tb_semaphore_bank.sv
// Directed bench for semaphore_bank: one table row per cycle, then reset sequences.
// Latency: rows are driven on the falling edge and checked on the next falling edge.
// Backpressure: rows respect the one-cycle Ack blackout of each core.
module tb_semaphore_bank;
    import semaphore_bank_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  crst;
    logic [1:0]  ack;
    logic [1:0]  status;
    logic [7:0]  rdata;
    logic [3:0]  locked;
    logic [3:0]  owner;

    int n_checks = 0;
    int n_err    = 0;

    semaphore_bank #(
        .NumberOfSemaphores (4),
        .NumberOfCores      (2),
        .DataWidth          (4),
        .AddrWidth          (8)
    ) dut (
        .SEMAPHOREBANK_Clk               (clk),
        .SEMAPHOREBANK_Reset_n           (rst_n),
        .SEMAPHOREBANK_Req_fromCPU       (req),
        .SEMAPHOREBANK_Op_fromCPU        (op),
        .SEMAPHOREBANK_Addr_fromCPU      (addr),
        .SEMAPHOREBANK_Data_fromCPU      (wdata),
        .SEMAPHOREBANK_CoreReset_fromCPU (crst),
        .SEMAPHOREBANK_Ack_toCPU         (ack),
        .SEMAPHOREBANK_Status_toCPU      (status),
        .SEMAPHOREBANK_Data_toCPU        (rdata),
        .SEMAPHOREBANK_Locked            (locked),
        .SEMAPHOREBANK_Owner             (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] op0;
        logic [7:0] a0;
        logic [3:0] d0;
        logic [1:0] op1;
        logic [7:0] a1;
        logic [3:0] d1;
        logic [1:0] crst;
        logic [1:0] ack;
        logic [1:0] st;
        logic [3:0] rd0;
        logic [3:0] rd1;
        logic [3:0] lk;
        logic [3:0] own;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] req_v,
        input logic [1:0] op0_v, input logic [7:0] a0_v, input logic [3:0] d0_v,
        input logic [1:0] op1_v, input logic [7:0] a1_v, input logic [3:0] d1_v,
        input logic [1:0] crst_v,
        input logic [1:0] ack_v, input logic [1:0] st_v,
        input logic [3:0] rd0_v, input logic [3:0] rd1_v,
        input logic [3:0] lk_v,  input logic [3:0] own_v);
        vec_t v;
        v.req = req_v; v.op0 = op0_v; v.a0 = a0_v; v.d0 = d0_v;
        v.op1 = op1_v; v.a1 = a1_v; v.d1 = d1_v; v.crst = crst_v;
        v.ack = ack_v; v.st = st_v; v.rd0 = rd0_v; v.rd1 = rd1_v;
        v.lk = lk_v; v.own = own_v;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req   = v.req;
        op    = {v.op1, v.op0};
        addr  = {v.a1, v.a0};
        wdata = {v.d1, v.d0};
        crst  = v.crst;
    endtask

    task automatic check_all(input int step, input logic [1:0] e_ack, input logic [1:0] e_st,
                             input logic [3:0] e_rd0, input logic [3:0] e_rd1,
                             input logic [3:0] e_lk, input logic [3:0] e_own);
        chk("ack",    step, 8'(ack),        8'(e_ack));
        chk("status", step, 8'(status),     8'(e_st));
        chk("rdata0", step, 8'(rdata[3:0]), 8'(e_rd0));
        chk("rdata1", step, 8'(rdata[7:4]), 8'(e_rd1));
        chk("locked", step, 8'(locked),     8'(e_lk));
        chk("owner",  step, 8'(owner),      8'(e_own));
    endtask

    initial begin
        vec_t idle;
        idle = mk(2'b00, OP_READ, 8'd0, 4'h0, OP_READ, 8'd0, 4'h0, 2'b00,
                  2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000);

        //            req    op0         a0    d0    op1         a1    d1    crst   ack    st     rd0   rd1   locked   owner
        vecs.push_back(mk(2'b01, OP_ACQUIRE, 8'd2, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_ACQUIRE, 8'd2, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b01, OP_WRITE,   8'd2, 4'hA, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_READ,    8'd2, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 4'hA, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0100, 4'b0000));
        // contention on entry 1: core0 first, then strict alternation
        vecs.push_back(mk(2'b11, OP_ACQUIRE, 8'd1, 4'h0, OP_ACQUIRE, 8'd1, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b11, OP_ACQUIRE, 8'd1, 4'h0, OP_ACQUIRE, 8'd1, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b11, OP_ACQUIRE, 8'd1, 4'h0, OP_ACQUIRE, 8'd1, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b11, OP_ACQUIRE, 8'd1, 4'h0, OP_ACQUIRE, 8'd1, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b11, OP_ACQUIRE, 8'd1, 4'h0, OP_ACQUIRE, 8'd1, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0110, 4'b0000));
        // release by non-owner, then by owner
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_RELEASE, 8'd1, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0110, 4'b0000));
        vecs.push_back(mk(2'b01, OP_RELEASE, 8'd1, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0100, 4'b0000));
        vecs.push_back(mk(2'b01, OP_ACQUIRE, 8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0101, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0101, 4'b0000));
        vecs.push_back(mk(2'b01, OP_ACQUIRE, 8'd3, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, 4'h0, 4'b1101, 4'b0000));
        // forced release of core0 races core1 ACQUIRE 3
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_ACQUIRE, 8'd3, 4'h0, 2'b01, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000));
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_ACQUIRE, 8'd3, 4'h0, 2'b00, 2'b10, 2'b10, 4'h0, 4'h0, 4'b1000, 4'b1000));
        // data survives forced release
        vecs.push_back(mk(2'b01, OP_READ,    8'd2, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b00, 4'hA, 4'h0, 4'b1000, 4'b1000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b1000, 4'b1000));
        // out-of-range address
        vecs.push_back(mk(2'b01, OP_ACQUIRE, 8'd9, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b01, 2'b00, 4'h0, 4'h0, 4'b1000, 4'b1000));
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_WRITE,   8'd3, 4'h5, 2'b00, 2'b10, 2'b10, 4'h0, 4'h0, 4'b1000, 4'b1000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b1000, 4'b1000));
        // core1 op completes in the same cycle as its own forced release
        vecs.push_back(mk(2'b10, OP_READ,    8'd0, 4'h0, OP_READ,    8'd3, 4'h0, 2'b10, 2'b10, 2'b10, 4'h0, 4'h5, 4'b0000, 4'b0000));
        vecs.push_back(mk(2'b00, OP_READ,    8'd0, 4'h0, OP_READ,    8'd0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000));

        // reset with a request pending: no ack may appear
        rst_n = 1'b0;
        drive(idle);
        req = 2'b01;
        op  = {OP_READ, OP_ACQUIRE};
        #3;
        check_all(-1, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        check_all(-2, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000);
        drive(idle);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check_all(i, vecs[i].ack, vecs[i].st, vecs[i].rd0, vecs[i].rd1, vecs[i].lk, vecs[i].own);
        end

        // core0 acquires 0 (pointer now past core0), then reset lands while Ack is showing
        drive(mk(2'b01, OP_ACQUIRE, 8'd0, 4'h0, OP_READ, 8'd0, 4'h0, 2'b00,
                 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000));
        @(posedge clk);
        @(negedge clk);
        check_all(100, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0001, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(101, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000);
        // both cores keep requesting through reset
        req = 2'b11;
        op  = {OP_ACQUIRE, OP_ACQUIRE};
        addr = {8'd1, 8'd1};
        @(negedge clk);
        @(negedge clk);
        check_all(102, 2'b00, 2'b00, 4'h0, 4'h0, 4'b0000, 4'b0000);
        // release reset: pointer restarts at core0, so core0 wins entry 1
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all(103, 2'b01, 2'b01, 4'h0, 4'h0, 4'b0010, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check_all(104, 2'b10, 2'b00, 4'h0, 4'h0, 4'b0010, 4'b0000);
        drive(idle);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/semaphore_bank.md
# semaphore_bank

Parametrised hardware semaphore bank for the multicore PLC unit: holds `NumberOfSemaphores` lock/owner/data entries shared by `NumberOfCores` CPUs and serialises their accesses through a round-robin arbiter. It supersedes the purely combinational semaphore data decoder with a registered request/acknowledge port per core, ownership checking and per-core forced release. It sits between the CPU cores and the shared semaphore storage and is the single point of truth for lock state.

## Interface
- `NumberOfSemaphores`, 4: entries in the bank (≥1).
- `NumberOfCores`, 2: requesting cores (≥2).
- `DataWidth`, 4: data word stored per semaphore.
- `AddrWidth`, 8: per-core address width; must be ≥ clog2(`NumberOfSemaphores`).

Ports (C = `NumberOfCores`, S = `NumberOfSemaphores`, OW = clog2(C)):
- `SEMAPHOREBANK_Clk`  in  1  single clock; all state changes on the rising edge.
- `SEMAPHOREBANK_Reset_n`  in  1  asynchronous, active-low reset.
- `SEMAPHOREBANK_Req_fromCPU`  in  C  per-core request level.
- `SEMAPHOREBANK_Op_fromCPU`  in  2*C  per-core opcode: 00 READ, 01 ACQUIRE, 10 RELEASE, 11 WRITE.
- `SEMAPHOREBANK_Addr_fromCPU`  in  AddrWidth*C  per-core semaphore index.
- `SEMAPHOREBANK_Data_fromCPU`  in  DataWidth*C  per-core write data.
- `SEMAPHOREBANK_CoreReset_fromCPU`  in  C  per-core forced release of everything that core owns.
- `SEMAPHOREBANK_Ack_toCPU`  out  C  one-cycle completion pulse.
- `SEMAPHOREBANK_Status_toCPU`  out  C  1 = op succeeded, valid with Ack.
- `SEMAPHOREBANK_Data_toCPU`  out  DataWidth*C  data word before the op, valid with Ack.
- `SEMAPHOREBANK_Locked`  out  S  current lock bit per semaphore.
- `SEMAPHOREBANK_Owner`  out  OW*S  current owner per semaphore (0 when unlocked).

## Operation
- Per-entry state: `locked`, `owner`, and `data`, each reset to 0.
- Eligible core: `Req` is high and its `Ack` is not high in the current cycle.
- The arbiter grants exactly one eligible core per cycle, round-robin. Search starts at the core after the last granted core. The pointer resets to 0, so core 0 has priority first.
- A granted op executes at that clock edge on entry `Addr`:
  - READ: no state change. Status = (locked and owner == core).
  - ACQUIRE:
    - Entry unlocked: set locked, set owner = core, Status 1.
    - Already owned by this core: no change, Status 1.
    - Owned by another core: no change, Status 0.
  - RELEASE: if owned by this core, clear locked and reset owner to 0, Status 1. Otherwise no change, Status 0.
  - WRITE: if owned by this core, `data` ← write data, Status 1. Otherwise no change, Status 0.
- `Data_toCPU` always returns the entry's `data` before the op.
- Address ≥ S: no state change, Status 0, Data 0, Ack still given.
- `CoreReset[k]` high for a cycle: at that edge, every entry owned by core k is unlocked and its owner cleared.
  - CoreReset takes priority over a same-cycle granted op from any core on those entries. An ACQUIRE by another core in that cycle sees the entry still locked and gets Status 0.
  - A granted op from core k itself in that cycle still completes, Status computed before the release.
- `data` is never cleared by RELEASE or CoreReset.

## Timing
- Reset: all outputs 0, all entries unlocked with owner 0 and data 0, arbiter pointer at 0. Assertion is asynchronous, mid-transaction included; pending requests are dropped with no Ack.
- Latency: grant at edge N, then `Ack`/`Status`/`Data_toCPU` registered and valid during the cycle after edge N. `Locked`/`Owner` are updated from edge N.
- Handshake:
  - Core holds `Req`, `Op`, `Addr` and `Data` stable until it sees `Ack`.
  - It may drop `Req` or present a new request in the Ack cycle. That request is arbitrated from the following cycle, so throughput is at most 1 op per 2 cycles per core.
- Bank throughput is 1 op/cycle under contention.
- Worst-case wait for a continuously requesting core: C−1 grants.
- Ack outputs of other cores are 0 when a core is not granted.

## Structure
- Shared package `semaphore_bank_pkg`:
  - opcode constants `OP_READ`, `OP_ACQUIRE`, `OP_RELEASE`, `OP_WRITE` (2 bits);
  - clog2-based width helpers for owner and index.
- Sub-module `rr_arbiter` (parameter N): request vector in, one-hot grant plus index out, with a registered pointer that advances past the winner on a grant.
- Top contains the entry register arrays, the op execution logic and the response registers.

## Test plan
- Reset then core0 ACQUIRE addr 2 → Ack next cycle, Status 1, Locked=0100, Owner[2]=0.
- Core0 owns 2; core1 ACQUIRE 2 → Status 0. Core0 WRITE 2 data 0xA, then core1 READ 2 → Status 0, Data 0xA.
- Both cores ACQUIRE 1 in the same cycle after reset → core0 wins (Status 1), core1 acked one cycle later with Status 0. Repeated contention then alternates grants 1, 0, 1…
- Core1 RELEASE of an entry owned by core0 → Status 0, entry unchanged. Core0 RELEASE → Status 1, Locked bit clears.
- Core0 owns 0 and 3; assert CoreReset[0] in the same cycle core1 ACQUIRE 3 is granted → core1 Status 0, Locked=0000. Core1 retry → Status 1.
- Addr 9 with S=4 → Ack, Status 0, Data 0, no state change. Reset_n low mid-request → all outputs 0 immediately, no Ack.
